// File: rtl/gpio_pkg.sv
// gpio_pkg: register map and address width shared by the GPIO block.
// Offsets are word indices taken from bus address bits [4:2].
package gpio_pkg;

  localparam int GPIO_AW = 3;

  localparam logic [GPIO_AW-1:0] GPIO_DATA_OUT  = 3'd0;
  localparam logic [GPIO_AW-1:0] GPIO_OUT_SET   = 3'd1;
  localparam logic [GPIO_AW-1:0] GPIO_OUT_CLR   = 3'd2;
  localparam logic [GPIO_AW-1:0] GPIO_DIR       = 3'd3;
  localparam logic [GPIO_AW-1:0] GPIO_DATA_IN   = 3'd4;
  localparam logic [GPIO_AW-1:0] GPIO_EDGE_STAT = 3'd5;
  localparam logic [GPIO_AW-1:0] GPIO_RISE_EN   = 3'd6;
  localparam logic [GPIO_AW-1:0] GPIO_FALL_EN   = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: WIDTH-wide, STAGES-deep input synchroniser chain.
// Ports: clk, reset (sync, active-high), d (async pads), q (synchronised).
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO with atomic set/clear, synchronised input
// readback and per-pin edge interrupts (built only with GPIO_EDGE_IRQ_EN).
// Ports: clk, reset, cs/we/addr/wdata bus in, rdata (registered read),
// pin_in (async pads), pin_out/pin_oe (to top-level tri-states), irq.
module mmio_gpio
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic               we,
  input  logic [GPIO_AW-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [WIDTH-1:0]   pin_in,
  output logic [WIDTH-1:0]   pin_out,
  output logic [WIDTH-1:0]   pin_oe,
  output logic               irq
);

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] stat_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [31:0]      rd_w;
  logic             unused_wdata;

  assign wr_en = cs & we;
  assign wd    = wdata[WIDTH-1:0];

  // Bits above WIDTH are architecturally ignored.
  assign unused_wdata = ^wdata;

  gpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pin_in),
    .q     (s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= OUT_RESET;
      dir_q  <= '0;
    end else if (wr_en) begin
      unique case (addr)
        GPIO_DATA_OUT: dout_q <= wd;
        GPIO_OUT_SET:  dout_q <= dout_q | wd;
        GPIO_OUT_CLR:  dout_q <= dout_q & ~wd;
        GPIO_DIR:      dir_q  <= wd;
        default: ;
      endcase
    end
  end

`ifdef GPIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] clr;

  assign hit = (s & ~p_q & rise_q)
             | (~s & p_q & fall_q);

  assign clr = (wr_en && addr == GPIO_EDGE_STAT)
             ? wd : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q    <= '0;
      stat_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      p_q    <= s;
      // A new edge beats a same-cycle W1C.
      stat_q <= (stat_q & ~clr) | hit;
      if (wr_en && addr == GPIO_RISE_EN)
        rise_q <= wd;
      if (wr_en && addr == GPIO_FALL_EN)
        fall_q <= wd;
    end
  end

  assign irq = |stat_q;
`else
  assign stat_q = '0;
  assign rise_q = '0;
  assign fall_q = '0;
  assign irq    = 1'b0;
`endif

  // Read mux samples pre-write state; rdata is refreshed every
  // cycle regardless of cs so the top-level mux can pick it up.
  always_comb begin
    rd_w = '0;
    unique case (addr)
      GPIO_DATA_OUT:  rd_w[WIDTH-1:0] = dout_q;
      GPIO_OUT_SET:   rd_w[WIDTH-1:0] = dout_q;
      GPIO_OUT_CLR:   rd_w[WIDTH-1:0] = dout_q;
      GPIO_DIR:       rd_w[WIDTH-1:0] = dir_q;
      GPIO_DATA_IN:   rd_w[WIDTH-1:0] = s;
      GPIO_EDGE_STAT: rd_w[WIDTH-1:0] = stat_q;
      GPIO_RISE_EN:   rd_w[WIDTH-1:0] = rise_q;
      GPIO_FALL_EN:   rd_w[WIDTH-1:0] = fall_q;
      default:        rd_w = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else begin
      rdata <= rd_w;
    end
  end

  assign pin_out = dout_q;
  assign pin_oe  = dir_q;

endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio: vector table, directed corner sequences and random
// traffic against a behavioural model of the GPIO register map.
module tb_mmio_gpio;

  localparam int S = 2;

`ifdef GPIO_EDGE_IRQ_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        cs;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  pin_in;
  logic [7:0]  pin_out;
  logic [7:0]  pin_oe;
  logic        irq;

  int checks;
  int failures;

  mmio_gpio #(
    .WIDTH       (8),
    .SYNC_STAGES (S),
    .OUT_RESET   (8'hA5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .pin_oe  (pin_oe),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: register values plus the history of pad
  // samples taken at each clock edge since reset.
  logic [7:0] m_out;
  logic [7:0] m_dir;
  logic [7:0] m_stat;
  logic [7:0] m_rise;
  logic [7:0] m_fall;
  logic [7:0] hist[$];

  // Pad value sampled k edges before the most recent one (0 if none).
  function automatic logic [7:0] ago(int k);
    int i;
    i = hist.size() - k;
    if (i < 0) return 8'h00;
    return hist[i];
  endfunction

  function automatic logic [7:0] mread(logic [2:0] a, logic [7:0] sv);
    case (a)
      3'd0, 3'd1, 3'd2: return m_out;
      3'd3: return m_dir;
      3'd4: return sv;
      3'd5: return EDGE ? m_stat : 8'h00;
      3'd6: return EDGE ? m_rise : 8'h00;
      default: return EDGE ? m_fall : 8'h00;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cycle(input logic r, input logic c, input logic w,
                       input logic [2:0] a, input logic [31:0] d,
                       input logic [7:0] pn);
    logic [7:0]  sv, pv, hit, clr;
    logic [31:0] e_rd;
    reset = r; cs = c; we = w; addr = a; wdata = d; pin_in = pn;
    sv = ago(S);
    pv = ago(S + 1);
    if (r) begin
      m_out = 8'hA5; m_dir = 0; m_stat = 0; m_rise = 0; m_fall = 0;
      hist.delete();
      e_rd = 0;
    end else begin
      e_rd = {24'h0, mread(a, sv)};
      hit = EDGE ? ((sv & ~pv & m_rise) | (~sv & pv & m_fall)) : 8'h00;
      clr = 8'h00;
      if (c && w) begin
        case (a)
          3'd0: m_out = d[7:0];
          3'd1: m_out = m_out | d[7:0];
          3'd2: m_out = m_out & ~d[7:0];
          3'd3: m_dir = d[7:0];
          3'd5: clr = d[7:0];
          3'd6: if (EDGE) m_rise = d[7:0];
          3'd7: if (EDGE) m_fall = d[7:0];
          default: ;
        endcase
      end
      m_stat = (m_stat & ~clr) | hit;
      hist.push_back(pn);
      if (hist.size() > 8) void'(hist.pop_front());
    end
    @(posedge clk);
    #1;
    chk("model_pin_out", {24'h0, pin_out}, {24'h0, m_out});
    chk("model_pin_oe", {24'h0, pin_oe}, {24'h0, m_dir});
    chk("model_irq", {31'h0, irq}, {31'h0, |m_stat});
    chk("model_rdata", rdata, e_rd);
  endtask

  task automatic idle(int n, logic [7:0] pn, logic [2:0] a);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, a, 0, pn);
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d, logic [7:0] pn);
    cycle(0, 1, 1, a, d, pn);
  endtask

  typedef struct {
    logic        cs;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  pin;
    logic [7:0]  eout;
    logic [7:0]  eoe;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[16];
  logic [7:0] rp;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1; cs = 0; we = 0; addr = 0; wdata = 0; pin_in = 0;

    tbl[0]  = '{0, 0, 3, 32'h0,        8'h00, 8'hA5, 8'h00, 32'h00};
    tbl[1]  = '{0, 0, 4, 32'h0,        8'h00, 8'hA5, 8'h00, 32'h00};
    tbl[2]  = '{0, 0, 5, 32'h0,        8'h00, 8'hA5, 8'h00, 32'h00};
    tbl[3]  = '{0, 0, 6, 32'h0,        8'h00, 8'hA5, 8'h00, 32'h00};
    tbl[4]  = '{0, 0, 7, 32'h0,        8'h00, 8'hA5, 8'h00, 32'h00};
    tbl[5]  = '{1, 1, 0, 32'h0F,       8'h00, 8'h0F, 8'h00, 32'hA5};
    tbl[6]  = '{1, 1, 1, 32'hF0,       8'h00, 8'hFF, 8'h00, 32'h0F};
    tbl[7]  = '{1, 1, 2, 32'h3C,       8'h00, 8'hC3, 8'h00, 32'hFF};
    tbl[8]  = '{1, 0, 1, 32'h0,        8'h00, 8'hC3, 8'h00, 32'hC3};
    tbl[9]  = '{1, 1, 3, 32'h5A,       8'h00, 8'hC3, 8'h5A, 32'h00};
    tbl[10] = '{1, 0, 3, 32'h0,        8'h00, 8'hC3, 8'h5A, 32'h5A};
    tbl[11] = '{1, 1, 0, 32'hFFFFFF00, 8'h00, 8'h00, 8'h5A, 32'hC3};
    tbl[12] = '{1, 0, 0, 32'h0,        8'h00, 8'h00, 8'h5A, 32'h00};
    tbl[13] = '{0, 1, 0, 32'hFF,       8'h00, 8'h00, 8'h5A, 32'h00};
    tbl[14] = '{1, 1, 4, 32'hFF,       8'h00, 8'h00, 8'h5A, 32'h00};
    tbl[15] = '{1, 1, 3, 32'h0,        8'h00, 8'h00, 8'h00, 32'h5A};

    cycle(1, 0, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 0, 8'h00);
    chk("rst_pin_out", {24'h0, pin_out}, 32'hA5);
    chk("rst_pin_oe", {24'h0, pin_oe}, 32'h00);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);

    for (int i = 0; i < 16; i++) begin
      cycle(0, tbl[i].cs, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].pin);
      chk($sformatf("tbl%0d_out", i), {24'h0, pin_out}, {24'h0, tbl[i].eout});
      chk($sformatf("tbl%0d_oe", i), {24'h0, pin_oe}, {24'h0, tbl[i].eoe});
      chk($sformatf("tbl%0d_rd", i), rdata, tbl[i].erd);
    end

    // Input latency: pad change sampled at edge N.
    idle(3, 8'h00, 4);
    cycle(0, 0, 0, 4, 0, 8'h5A);
    chk("lat_n0", rdata, 32'h00);
    idle(1, 8'h5A, 4);
    chk("lat_n1", rdata, 32'h00);
    idle(1, 8'h5A, 4);
    chk("lat_n2", rdata, 32'h5A);
    idle(1, 8'h5A, 4);
    chk("lat_n3", rdata, 32'h5A);

`ifdef GPIO_EDGE_IRQ_EN
    idle(4, 8'h00, 5);
    wr(6, 32'h01, 8'h00);
    wr(7, 32'h02, 8'h00);
    idle(4, 8'h02, 5);
    chk("edge_disabled_rise", rdata, 32'h00);
    chk("edge_disabled_irq", {31'h0, irq}, 32'h0);
    cycle(0, 0, 0, 5, 0, 8'h03);
    idle(1, 8'h03, 5);
    chk("edge_irq_n1", {31'h0, irq}, 32'h0);
    idle(1, 8'h03, 5);
    chk("edge_irq_n2", {31'h0, irq}, 32'h1);
    idle(1, 8'h03, 5);
    chk("edge_stat_01", rdata, 32'h01);
    idle(4, 8'h01, 5);
    chk("edge_stat_03", rdata, 32'h03);
    idle(4, 8'h02, 5);
    chk("edge_stat_hold", rdata, 32'h03);
    wr(5, 32'h01, 8'h02);
    idle(1, 8'h02, 5);
    chk("w1c_02", rdata, 32'h02);
    wr(5, 32'h02, 8'h02);
    chk("w1c_irq0", {31'h0, irq}, 32'h0);
    idle(1, 8'h02, 5);
    chk("w1c_00", rdata, 32'h00);

    // Set beats W1C on the same bit in the same cycle.
    idle(4, 8'h03, 5);
    idle(4, 8'h02, 5);
    chk("race_pre", rdata, 32'h01);
    cycle(0, 0, 0, 5, 0, 8'h03);
    idle(1, 8'h03, 5);
    wr(5, 32'h01, 8'h03);
    chk("race_irq", {31'h0, irq}, 32'h1);
    idle(1, 8'h03, 5);
    chk("race_stat", rdata, 32'h01);

    // Reset with a concurrent write, pads held high afterwards.
    wr(0, 32'hFF, 8'hFF);
    chk("pre_rst_out", {24'h0, pin_out}, 32'hFF);
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    cycle(1, 1, 1, 0, 32'h12, 8'hFF);
    chk("midrst_out", {24'h0, pin_out}, 32'hA5);
    chk("midrst_oe", {24'h0, pin_oe}, 32'h00);
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    chk("midrst_rd", rdata, 32'h0);
    idle(6, 8'hFF, 5);
    wr(6, 32'hFF, 8'hFF);
    idle(4, 8'hFF, 5);
    chk("static_en_irq", {31'h0, irq}, 32'h0);
    chk("static_en_stat", rdata, 32'h00);
`else
    wr(6, 32'hFF, 8'h00);
    wr(7, 32'hFF, 8'h00);
    idle(4, 8'hFF, 5);
    idle(4, 8'h00, 5);
    chk("noedge_irq", {31'h0, irq}, 32'h0);
    chk("noedge_stat", rdata, 32'h00);
    idle(1, 8'h00, 6);
    chk("noedge_rise", rdata, 32'h00);
`endif

    rp = 8'h00;
    for (int i = 0; i < 500; i++) begin
      logic r, c, w;
      r = ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 2) == 0) rp = 8'($urandom);
      cycle(r, c, w, 3'($urandom_range(0, 7)), $urandom, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
